// File: rtl/seq_det_arbiter.sv
// Two-requester round-robin front end for a serial repeated-bit detector.
// Optional longest-run reporting is enabled by defining SEQDET_MAX_RUN_EN.
module seq_det_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt1,
    output logic             busy,
    output logic             ser_valid,
    output logic             ser_bit,
    output logic             match,
    output logic             done,
    output logic             done_id,
    output logic [CNT_W-1:0] match_cnt
`ifdef SEQDET_MAX_RUN_EN
    ,
    output logic [CNT_W-1:0] max_run
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_shift;
    logic [CNT_W-1:0]   r_bitcnt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_prev_bit;
    logic               r_owner;
    logic               r_rr_ptr;
    logic               r_gnt0;
    logic               r_gnt1;
    logic               r_done;
    logic               r_done_id;
    logic [CNT_W-1:0]   r_match_cnt;

    logic               w_ser_valid;
    logic               w_ser_bit;
    logic               w_first;
    logic               w_last;
    logic               w_match;
    logic               w_pick1;

    // Serial datapath decode and round-robin choice.
    always_comb begin
        w_ser_valid = (r_state == SHIFT);
        w_ser_bit   = w_ser_valid & r_shift[WIDTH-1];
        w_first     = (r_bitcnt == CNT_W'(WIDTH-1));
        w_last      = (r_bitcnt == {CNT_W{1'b0}});
        w_match     = 1'b0;
        if (w_ser_valid && !w_first) begin
            w_match = (w_ser_bit == r_prev_bit);
        end else begin
            w_match = 1'b0;
        end
        // r_rr_ptr set means requester 1 wins a tie.
        w_pick1 = req1 & (~req0 | r_rr_ptr);
    end

    // Main FSM: arbitration, serialization, counting and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_shift     <= {WIDTH{1'b0}};
            r_bitcnt    <= {CNT_W{1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
            r_prev_bit  <= 1'b0;
            r_owner     <= 1'b0;
            r_rr_ptr    <= 1'b0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_done      <= 1'b0;
            r_done_id   <= 1'b0;
            r_match_cnt <= {CNT_W{1'b0}};
        end else begin
            r_gnt0 <= 1'b0;
            r_gnt1 <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req0 || req1) begin
                        r_state  <= SHIFT;
                        r_shift  <= w_pick1 ? data1 : data0;
                        r_bitcnt <= CNT_W'(WIDTH-1);
                        r_cnt    <= {CNT_W{1'b0}};
                        r_owner  <= w_pick1;
                        r_rr_ptr <= ~w_pick1;
                        r_gnt0   <= ~w_pick1;
                        r_gnt1   <= w_pick1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SHIFT: begin
                    r_shift    <= {r_shift[WIDTH-2:0], 1'b0};
                    r_prev_bit <= w_ser_bit;
                    r_cnt      <= r_cnt + {{(CNT_W-1){1'b0}}, w_match};
                    if (w_last) begin
                        r_state     <= DONE;
                        r_done      <= 1'b1;
                        r_done_id   <= r_owner;
                        r_match_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, w_match};
                    end else begin
                        r_bitcnt <= r_bitcnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign busy      = (r_state != IDLE);
    assign ser_valid = w_ser_valid;
    assign ser_bit   = w_ser_bit;
    assign match     = w_match;
    assign done      = r_done;
    assign done_id   = r_done_id;
    assign match_cnt = r_match_cnt;

`ifdef SEQDET_MAX_RUN_EN
    logic [CNT_W-1:0] r_run;
    logic [CNT_W-1:0] r_run_max;
    logic [CNT_W-1:0] r_max_run;
    logic [CNT_W-1:0] w_run_now;
    logic [CNT_W-1:0] w_max_now;

    // Length of the run ending at the current bit, and the best so far.
    always_comb begin
        w_run_now = CNT_W'(1);
        w_max_now = r_run_max;
        if (w_match) begin
            w_run_now = r_run + CNT_W'(1);
        end else begin
            w_run_now = CNT_W'(1);
        end
        if (w_first || (w_run_now > r_run_max)) begin
            w_max_now = w_run_now;
        end else begin
            w_max_now = r_run_max;
        end
    end

    // Run tracking registers; result published alongside match_cnt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run     <= {CNT_W{1'b0}};
            r_run_max <= {CNT_W{1'b0}};
            r_max_run <= {CNT_W{1'b0}};
        end else if (r_state == SHIFT) begin
            r_run     <= w_run_now;
            r_run_max <= w_max_now;
            if (w_last) begin
                r_max_run <= w_max_now;
            end
        end
    end

    assign max_run = r_max_run;
`else
    // Without run tracking the serial detector above is the whole datapath.
`endif

endmodule
